// File: rtl/dff_pipe_pkg.sv
// ---------------------------------------------------------------------------
// dff_pkg
// Shared definitions for the dff_pipe elastic pipeline register.
//   pipe_mode_e : selects lockstep (global stall) or collapsing (per-stage
//                 accept when empty) advance behaviour.
//   clog2_occ   : width of the occupancy count for a given pipe depth
//                 (must be able to represent 0..depth inclusive).
// ---------------------------------------------------------------------------
package dff_pkg;

    typedef enum logic {
        MODE_LOCKSTEP = 1'b0,
        MODE_COLLAPSE = 1'b1
    } pipe_mode_e;

    // Bits needed to hold a count of 0..depth. A depth below 1 is illegal,
    // but a 1-bit result keeps the port width legal if it ever happens.
    function automatic int clog2_occ(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// ---------------------------------------------------------------------------
// dff_pipe_stage
// One stage of the elastic pipe: a valid bit plus a data register.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (valid=0, data=RST_VAL)
//   flush      : synchronous clear of the valid bit, data untouched
//   i_load     : stage takes the upstream value this edge
//   i_up_valid : upstream valid
//   i_up_data  : upstream payload
//   o_valid    : stage holds a valid entry
//   o_data     : stage payload
// ---------------------------------------------------------------------------
module dff_pipe_stage
    import dff_pkg::*;
#(
    parameter int              DW      = 32,
    parameter logic [DW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          i_load,
    input  logic          i_up_valid,
    input  logic [DW-1:0] i_up_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    // Flush wins over a load: the entry that would have been taken is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_up_valid;
        end
    end

    // Data only moves when a real entry moves in, so bubbles never toggle
    // the wide register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= RST_VAL;
        end else if (!flush && i_load && i_up_valid) begin
            r_data <= i_up_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/dff_pipe.sv
// ---------------------------------------------------------------------------
// dff_pipe
// Elastic pipeline register: DEPTH valid/data stages with valid/ready
// handshake on both ends, optional bubble collapsing and synchronous flush.
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-high reset
//   flush      : drop all in-flight entries at the next edge
//   in_valid   : producer has data
//   in_ready   : pipe accepts data this cycle
//   in_data    : producer payload
//   out_valid  : last stage holds valid data
//   out_ready  : consumer accepts this cycle
//   out_data   : last stage payload
//   occupancy  : number of valid stages
// in_ready is combinational from out_ready (through up to DEPTH gates when
// collapsing, one gate in lockstep); add a skid buffer upstream if needed.
// ---------------------------------------------------------------------------
module dff_pipe
    import dff_pkg::*;
#(
    parameter int              DW       = 32,
    parameter int              DEPTH    = 3,
    parameter logic [DW-1:0]   RST_VAL  = '0,
    parameter int              COLLAPSE = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DW-1:0]                  in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DW-1:0]                  out_data,
    output logic [clog2_occ(DEPTH)-1:0]    occupancy
);

    localparam int         OW   = clog2_occ(DEPTH);
    localparam pipe_mode_e MODE = (COLLAPSE != 0) ? MODE_COLLAPSE : MODE_LOCKSTEP;

    logic [DEPTH-1:0] w_valid;
    logic [DW-1:0]    w_data    [DEPTH];
    logic [DEPTH-1:0] w_up_valid;
    logic [DW-1:0]    w_up_data [DEPTH];
    logic [DEPTH-1:0] w_load;
    logic             w_in_rdy;
    logic [OW-1:0]    w_occ;

    // -----------------------------------------------------------------------
    // Stage chain
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign w_up_valid[gi] = in_valid;
            assign w_up_data[gi]  = in_data;
        end else begin : g_body
            assign w_up_valid[gi] = w_valid[gi-1];
            assign w_up_data[gi]  = w_data[gi-1];
        end

        dff_pipe_stage #(
            .DW      (DW),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .i_load     (w_load[gi]),
            .i_up_valid (w_up_valid[gi]),
            .i_up_data  (w_up_data[gi]),
            .o_valid    (w_valid[gi]),
            .o_data     (w_data[gi])
        );
    end

    // -----------------------------------------------------------------------
    // Advance control
    // -----------------------------------------------------------------------
    if (MODE == MODE_COLLAPSE) begin : g_collapse
        // A stage can take a new entry if it is empty or its own entry is
        // leaving this cycle; this ripples back from the consumer.
        logic [DEPTH:0] w_rdy;
        assign w_rdy[DEPTH] = out_ready;
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rdy
            assign w_rdy[gi]  = !w_valid[gi] || w_rdy[gi+1];
            assign w_load[gi] = w_rdy[gi];
        end
        assign w_in_rdy = w_rdy[0];
    end else begin : g_lockstep
        // Whole pipe shifts together unless the tail is stuck.
        logic w_adv;
        assign w_adv = out_ready || !w_valid[DEPTH-1];
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ld
            assign w_load[gi] = w_adv;
        end
        assign w_in_rdy = w_adv;
    end

    // Refuse input during flush (it would be dropped) and while in reset.
    assign in_ready = w_in_rdy && !flush && !rst;

    // out_valid is deliberately not masked by flush: a transfer in the flush
    // cycle still completes from the consumer's point of view.
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];

    // -----------------------------------------------------------------------
    // Occupancy = popcount of stage valid bits
    // -----------------------------------------------------------------------
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OW'(w_valid[i]);
        end
    end

    assign occupancy = w_occ;

endmodule

// File: tb/tb_dff_pipe.sv
// ---------------------------------------------------------------------------
// tb_dff_pipe
// Six dff_pipe instances with different DEPTH/COLLAPSE settings. Only one is
// exercised at a time; its accepted inputs are pushed to a scoreboard queue
// and popped on each output transfer.
//   0: DEPTH=3 COLLAPSE=1 RST_VAL=DEADBEEF   1: DEPTH=3 COLLAPSE=0
//   2: DEPTH=1 COLLAPSE=1                    3: DEPTH=4 COLLAPSE=1
//   4: DEPTH=1 COLLAPSE=0                    5: DEPTH=4 COLLAPSE=0
// ---------------------------------------------------------------------------
module tb_dff_pipe;

    localparam int          NI    = 6;
    localparam logic [31:0] RV0   = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        iv   [NI];
    logic        ordy [NI];
    logic        fl   [NI];
    logic [31:0] idat [NI];
    wire  [NI-1:0] irdy;
    wire  [NI-1:0] ov;
    wire  [31:0] odat [NI];
    wire  [2:0]  occ  [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int          DEP = (gi < 2) ? 3 : ((gi == 2 || gi == 4) ? 1 : 4);
        localparam int          COL = (gi == 1 || gi >= 4) ? 0 : 1;
        localparam logic [31:0] RV  = (gi == 0) ? RV0 : 32'h0;
        localparam int          OWL = $clog2(DEP + 1);

        logic [OWL-1:0] occ_l;

        dff_pipe #(
            .DW       (32),
            .DEPTH    (DEP),
            .RST_VAL  (RV),
            .COLLAPSE (COL)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (fl[gi]),
            .in_valid  (iv[gi]),
            .in_ready  (irdy[gi]),
            .in_data   (idat[gi]),
            .out_valid (ov[gi]),
            .out_ready (ordy[gi]),
            .out_data  (odat[gi]),
            .occupancy (occ_l)
        );

        assign occ[gi] = 3'(occ_l);
    end

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          first_in;
    int          first_out;
    int          n_out;
    logic        last_ix;
    logic        last_ox;
    logic [31:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on instance k: sample handshakes mid-cycle, update the
    // scoreboard, step the clock, then compare occupancy with the model.
    task automatic tick(input int k);
        logic        ix;
        logic        ox;
        logic [31:0] exp_d;
        @(negedge clk);
        ix = iv[k] & irdy[k];
        ox = ov[k] & ordy[k];
        if (fl[k]) check("flush_in_ready", 32'(irdy[k]), 32'd0);
        if (ox) begin
            check("out_when_expected", 32'(ov[k]), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                exp_d = sb.pop_front();
                check("out_data_order", odat[k], exp_d);
                $display("xfer inst=%0d cyc=%0d out data=0x%08h", k, cyc, odat[k]);
            end
            n_out++;
            if (first_out < 0) first_out = cyc;
        end
        if (ix) begin
            sb.push_back(idat[k]);
            $display("xfer inst=%0d cyc=%0d in  data=0x%08h", k, cyc, idat[k]);
            if (first_in < 0) first_in = cyc;
        end
        if (fl[k]) sb.delete();
        last_ix = ix;
        last_ox = ox;
        @(posedge clk);
        #1;
        cyc++;
        check("occupancy", 32'(occ[k]), 32'(sb.size()));
    endtask

    task automatic drain(input int k, input int max_cyc);
        int n;
        iv[k]   = 1'b0;
        fl[k]   = 1'b0;
        ordy[k] = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            tick(k);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("drain_out_valid", 32'(ov[k]), 32'd0);
    endtask

    task automatic reset_marks();
        first_in  = -1;
        first_out = -1;
        n_out     = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] bp_list [4];
        int          idx;

        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; fl[i] = 1'b0; idat[i] = 32'h0;
        end
        reset_marks();

        // ---------------- reset state ----------------
        iv[0] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(ov[0]), 32'd0);
        check("rst_out_data", odat[0], RV0);
        check("rst_occupancy", 32'(occ[0]), 32'd0);
        check("rst_in_ready", 32'(irdy[0]), 32'd0);
        check("rst_out_data_inst1", odat[1], 32'h0);
        iv[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // ---------------- streaming, inst 0 ----------------
        reset_marks();
        ordy[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            iv[0]   = 1'b1;
            idat[0] = 32'(i);
            tick(0);
            check("stream_accept", 32'(last_ix), 32'd1);
        end
        drain(0, 20);
        check("stream_latency", 32'(first_out - first_in), 32'd3);
        check("stream_count", 32'(n_out), 32'd8);

        // ---------------- backpressure fill, inst 0 ----------------
        bp_list[0] = 32'hA; bp_list[1] = 32'hB; bp_list[2] = 32'hC; bp_list[3] = 32'hD;
        ordy[0] = 1'b0;
        idx = 0;
        repeat (5) begin
            iv[0]   = 1'b1;
            idat[0] = bp_list[idx];
            tick(0);
            if (last_ix) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd3);
        check("bp_full_in_ready", 32'(irdy[0]), 32'd0);
        check("bp_full_occ", 32'(occ[0]), 32'd3);
        ordy[0] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick(0);
            if (j == 0) check("bp_full_accept_emit", 32'(last_ix), 32'd1);
            if (last_ix) idx++;
            if (idx == 4) iv[0] = 1'b0;
            check("bp_flow_nogap", 32'(last_ox), 32'd1);
        end
        drain(0, 10);

        // ---------------- bubble collapse, inst 0 ----------------
        ordy[0] = 1'b0;
        iv[0] = 1'b1; idat[0] = 32'h55;
        tick(0);
        check("col_accept_55", 32'(last_ix), 32'd1);
        iv[0] = 1'b0;
        tick(0);
        tick(0);
        check("col_out_valid", 32'(ov[0]), 32'd1);
        check("col_out_data", odat[0], 32'h55);
        check("col_in_ready_1", 32'(irdy[0]), 32'd1);
        iv[0] = 1'b1; idat[0] = 32'h66;
        tick(0);
        check("col_accept_66", 32'(last_ix), 32'd1);
        idat[0] = 32'h77;
        tick(0);
        check("col_accept_77", 32'(last_ix), 32'd1);
        check("col_full_in_ready", 32'(irdy[0]), 32'd0);
        drain(0, 10);

        // ---------------- lockstep, inst 1 ----------------
        ordy[1] = 1'b0;
        iv[1] = 1'b1; idat[1] = 32'h55;
        tick(1);
        check("lock_accept_55", 32'(last_ix), 32'd1);
        iv[1] = 1'b0;
        tick(1);
        tick(1);
        check("lock_out_valid", 32'(ov[1]), 32'd1);
        check("lock_out_data", odat[1], 32'h55);
        check("lock_in_ready", 32'(irdy[1]), 32'd0);
        iv[1] = 1'b1; idat[1] = 32'h66;
        tick(1);
        check("lock_stalled", 32'(last_ix), 32'd0);
        drain(1, 10);

        // ---------------- flush, inst 0 ----------------
        ordy[0] = 1'b0;
        iv[0] = 1'b1; idat[0] = 32'h11; tick(0);
        idat[0] = 32'h22; tick(0);
        check("flush_pre_occ", 32'(occ[0]), 32'd2);
        idat[0] = 32'h99; fl[0] = 1'b1;
        tick(0);
        check("flush_not_accepted", 32'(last_ix), 32'd0);
        fl[0] = 1'b0; iv[0] = 1'b0;
        check("flush_out_valid", 32'(ov[0]), 32'd0);
        ordy[0] = 1'b1;
        repeat (4) tick(0);
        // flush coinciding with an output transfer
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idat[0] = 32'h30 + 32'(i);
            tick(0);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1; fl[0] = 1'b1;
        tick(0);
        check("flush_out_xfer_seen", 32'(last_ox), 32'd1);
        fl[0] = 1'b0;
        check("flush2_out_valid", 32'(ov[0]), 32'd0);

        // ---------------- async reset mid-stream, inst 0 ----------------
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idat[0] = 32'hC1 + 32'(i);
            tick(0);
        end
        check("arst_pre_occ", 32'(occ[0]), 32'd3);
        ordy[0] = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(ov[0]), 32'd0);
        check("arst_out_data", odat[0], RV0);
        check("arst_occ", 32'(occ[0]), 32'd0);
        check("arst_in_ready", 32'(irdy[0]), 32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        reset_marks();
        iv[0] = 1'b1; idat[0] = 32'h77;
        tick(0);
        check("arst_first_edge_accept", 32'(last_ix), 32'd1);
        iv[0] = 1'b0;
        drain(0, 10);
        check("arst_latency", 32'(first_out - first_in), 32'd3);

        // ---------------- random valid/ready, inst 2..5 ----------------
        for (int k = 2; k < NI; k++) begin
            sb.delete();
            reset_marks();
            repeat (2500) begin
                iv[k]   = ($urandom % 4) != 0;
                idat[k] = $urandom;
                ordy[k] = ($urandom % 3) != 0;
                fl[k]   = ($urandom % 97) == 0;
                tick(k);
            end
            drain(k, 20);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised elastic pipeline register: a chain of DEPTH enabled DFF stages, each with a valid bit and valid/ready handshake on both ends.
- Successor to the single enabled DFF. Used wherever a datapath needs N cycles of retiming with backpressure, optional bubble collapsing and a synchronous flush.
- Sits between producer and consumer blocks in the datapath. Carries no data transformation.

Parameters:
DW, 32, payload width in bits (>=1)
DEPTH, 3, number of register stages (>=1)
RST_VAL, '0, reset value of every stage data register (DW bits)
COLLAPSE, 1, 1 = a stage accepts whenever it is empty (bubbles collapse); 0 = whole pipe advances in lockstep (global stall)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous flush: drop all in-flight entries
in_valid  input  1  producer has data
in_ready  output  1  pipe accepts data this cycle
in_data  input  DW  producer payload
out_valid  output  1  last stage holds valid data
out_ready  input  1  consumer accepts this cycle
out_data  output  DW  last stage payload
occupancy  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- State per stage i (0..DEPTH-1): v[i], d[i]. Stage 0 is fed by in_*; stage DEPTH-1 drives out_valid=v[DEPTH-1], out_data=d[DEPTH-1].
- Reset (async assert, any cycle): all v=0, all d=RST_VAL. Outputs: out_valid=0, out_data=RST_VAL, occupancy=0, in_ready=0 while rst high. Deassert is synchronous to clk; no transfer on the first edge after deassert is lost.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready. No transfer happens when valid is low, regardless of ready.
- COLLAPSE=1: rdy[DEPTH]=out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready=rdy[0]. Stage i loads from stage i-1 (or the input) when rdy[i]. v[i] next = upstream valid if rdy[i], else held.
- COLLAPSE=0: adv = out_ready | !v[DEPTH-1]; in_ready=adv. When adv, every stage shifts one position (v and d). Otherwise all state is held.
- Data enable: d[i] is written only when stage i loads AND upstream valid=1. Otherwise d[i] holds (no bubble data written; power).
- Latency: empty pipe with out_ready=1 gives out_valid DEPTH cycles after the input transfer. Throughput is 1/cycle with no stall.
- Full (all v=1, out_ready=0): in_ready=0. Full with out_ready=1: in_ready=1, accept and emit in the same cycle.
- Ordering: strict FIFO order. No loss or duplication under any valid/ready pattern.
- flush: in_ready=0 in the flush cycle. Next edge clears all v; d unchanged. If flush and an output transfer coincide, the consumer still sees the transfer (out_valid is not masked combinationally). flush has priority over loading.
- occupancy = popcount(v), registered-state derived (combinational from v).
- in_ready depends combinationally on out_ready: a DEPTH-long chain for COLLAPSE=1, one gate for COLLAPSE=0. This is documented; integrators add a skid buffer if timing requires.
- DEPTH=1: single stage. Behaves as an enabled DFF with valid and handshake.

Decomposition:
- Package dff_pkg: typedef pipe_mode_e {MODE_LOCKSTEP=0, MODE_COLLAPSE=1}; function clog2_occ(depth) for occupancy width.
- Sub-module dff_pipe_stage: one v/d register pair with load enable, flush and RST_VAL. dff_pipe instantiates it DEPTH times in a generate loop, plus the ready chain and popcount.

Test Plan:
- Streaming: DW=32, DEPTH=3, out_ready=1, inputs 0x1..0x8 back-to-back -> out_valid first high 3 cycles after the first accept; out_data 0x1..0x8 consecutive; in_ready never low.
- Backpressure fill: out_ready=0, push 0xA,0xB,0xC,0xD -> 0xA..0xC accepted, in_ready=0 after the 3rd; occupancy=3. Then out_ready=1 -> outputs 0xA,0xB,0xC,0xD in order, no gaps once flowing.
- Bubble collapse: COLLAPSE=1, out_ready=0, single push 0x55 -> reaches stage 2 after 3 cycles, in_ready stays 1 until 3 entries held. COLLAPSE=0, same stimulus -> 0x55 advances only when adv; in_ready=0 once stage 2 is valid.
- Flush: 2 entries in flight, assert flush for 1 cycle with in_valid=1 -> in_ready=0 that cycle; next cycle occupancy=0, out_valid=0; the input was not accepted.
- Async reset mid-stream: assert rst between clock edges with occupancy=3 -> out_valid=0 and out_data=RST_VAL immediately, before the next edge; after release, a new push 0x77 emerges after DEPTH cycles.
- Random valid/ready (10k cycles, DEPTH=1 and 4, both modes) -> scoreboard matches; no drop or duplicate; occupancy equals pushes minus pops.
